// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker
// Producer side of the decode-stage hazard interface. Decoded instructions
// (operation plus destination/source register addresses) move through the
// ID/EX, EX/MEM and MEM/WB tracking registers that feed the forwarding logic.
// A stall request holds the decode slot and puts a bubble into ID/EX. A branch
// flush drops the decode instruction. A global hold freezes every register.
// A watchdog counts how many stall cycles have occurred in a row.
//
// Handshake: decode presents an instruction with dec_valid. The instruction is
// taken into ID/EX on a rising edge only when dec_accept is high in that cycle.
// dec_accept = dec_valid & ~hold & ~flush & ~stall_req, and it is purely
// combinational. Upstream must keep the instruction stable, and advance only
// after an edge at which dec_accept was 1. An instruction that is present
// during a flush cycle is discarded. Upstream replaces it and does not retry.
module pipe_hazard_tracker #(
  parameter int                OP_W        = 8,
  parameter int                ADDR_W      = 5,
  parameter logic [OP_W-1:0]   NOP_OP      = 8'h00,
  parameter logic [ADDR_W-1:0] BUBBLE_ADDR = 5'd0,
  parameter int                MAX_STALL   = 15,
  parameter int                CNT_W       = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dec_valid,
  input  logic [OP_W-1:0]   dec_operation,
  input  logic [ADDR_W-1:0] dec_addr_low,
  input  logic [ADDR_W-1:0] dec_addr_high,
  input  logic              stall_req,
  input  logic              flush,
  input  logic              hold,
  output logic              dec_accept,
  output logic [OP_W-1:0]   id_ex_operation,
  output logic [ADDR_W-1:0] id_ex_addr_low,
  output logic [ADDR_W-1:0] id_ex_addr_high,
  output logic [OP_W-1:0]   ex_mem_operation,
  output logic [ADDR_W-1:0] ex_mem_addr_low,
  output logic [ADDR_W-1:0] ex_mem_addr_high,
  output logic [OP_W-1:0]   mem_wb_operation,
  output logic [ADDR_W-1:0] mem_wb_addr_low,
  output logic [ADDR_W-1:0] mem_wb_addr_high,
  output logic              id_ex_valid,
  output logic              ex_mem_valid,
  output logic              mem_wb_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic              stall_timeout
);

  // One tracking slot: what the forwarding logic needs to know about an instruction
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
  } stage_t;

  // A bubble uses r0 addresses, so it can never look like a live hazard
  localparam stage_t BUBBLE = '{valid: 1'b0, op: NOP_OP, lo: BUBBLE_ADDR, hi: BUBBLE_ADDR};

  localparam logic [CNT_W-1:0] MAX_STALL_C = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  // The kind of cycle after the priority hold > flush > stall_req > normal is resolved
  typedef enum logic [1:0] {
    CYC_NORMAL = 2'd0,
    CYC_STALL  = 2'd1,
    CYC_FLUSH  = 2'd2,
    CYC_HOLD   = 2'd3
  } cyc_t;

  cyc_t             w_cyc;
  stage_t           w_dec_stage;
  logic [CNT_W-1:0] w_cnt_next;

  stage_t           r_id_ex;
  stage_t           r_ex_mem;
  stage_t           r_mem_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_stall_timeout;

  // Resolve the cycle type from the control inputs, highest priority first
  always_comb begin
    w_cyc = CYC_NORMAL;
    if (hold)           w_cyc = CYC_HOLD;
    else if (flush)     w_cyc = CYC_FLUSH;
    else if (stall_req) w_cyc = CYC_STALL;
  end

  // Form the candidate ID/EX entry from the decode slot. With no instruction, this is a bubble.
  always_comb begin
    w_dec_stage = BUBBLE;
    if (dec_valid) begin
      w_dec_stage.valid = 1'b1;
      w_dec_stage.op    = dec_operation;
      w_dec_stage.lo    = dec_addr_low;
      w_dec_stage.hi    = dec_addr_high;
    end
  end

  // Next stall count. It counts consecutive effective stalls, saturates, and is kept during hold.
  always_comb begin
    w_cnt_next = r_stall_cnt;
    case (w_cyc)
      CYC_HOLD:   w_cnt_next = r_stall_cnt;
      CYC_STALL:  w_cnt_next = (r_stall_cnt == CNT_SAT) ? r_stall_cnt
                                                         : r_stall_cnt + CNT_W'(1);
      CYC_FLUSH:  w_cnt_next = '0;
      CYC_NORMAL: w_cnt_next = '0;
      default:    w_cnt_next = r_stall_cnt;
    endcase
  end

  // Advance the three tracking slots. Stall and flush both put a bubble into ID/EX.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_ex  <= BUBBLE;
      r_ex_mem <= BUBBLE;
      r_mem_wb <= BUBBLE;
    end else begin
      case (w_cyc)
        CYC_NORMAL: begin
          r_mem_wb <= r_ex_mem;
          r_ex_mem <= r_id_ex;
          r_id_ex  <= w_dec_stage;
        end
        CYC_STALL, CYC_FLUSH: begin
          r_mem_wb <= r_ex_mem;
          r_ex_mem <= r_id_ex;
          r_id_ex  <= BUBBLE;
        end
        default: begin
          r_mem_wb <= r_mem_wb;
          r_ex_mem <= r_ex_mem;
          r_id_ex  <= r_id_ex;
        end
      endcase
    end
  end

  // Stall watchdog. The timeout flag is derived from the count it is registered with, so the two always agree.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_stall_cnt     <= w_cnt_next;
      r_stall_timeout <= (w_cnt_next >= MAX_STALL_C);
    end
  end

  assign dec_accept = dec_valid & ~hold & ~flush & ~stall_req;

  // Every tracking output comes straight from a register, so there is no loop through the forwarding logic
  assign id_ex_operation  = r_id_ex.op;
  assign id_ex_addr_low   = r_id_ex.lo;
  assign id_ex_addr_high  = r_id_ex.hi;
  assign id_ex_valid      = r_id_ex.valid;
  assign ex_mem_operation = r_ex_mem.op;
  assign ex_mem_addr_low  = r_ex_mem.lo;
  assign ex_mem_addr_high = r_ex_mem.hi;
  assign ex_mem_valid     = r_ex_mem.valid;
  assign mem_wb_operation = r_mem_wb.op;
  assign mem_wb_addr_low  = r_mem_wb.lo;
  assign mem_wb_addr_high = r_mem_wb.hi;
  assign mem_wb_valid     = r_mem_wb.valid;
  assign stall_count      = r_stall_cnt;
  assign stall_timeout    = r_stall_timeout;

endmodule
